muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers for the P7 pipelined MIPS core. It sits in the EX stage next to the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and models the fixed execution latency with a counter-driven FSM. It exports `busy` to the hazard unit, which stalls MFHI/MFLO/mult-div instructions while `start || busy`. The `kill` input suppresses a start when an exception or interrupt is taken against the EX-stage instruction.

---
 rtl/muldiv_ctrl.sv | 145 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at accept time and held in res_hi/res_lo; a down-counter
// models the fixed latency, and hi/lo are updated on the final busy edge.
module muldiv_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        kill,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic               r_no_commit;

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_b_safe;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_uq_mag;
    logic [31:0]        w_ur_mag;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_accept;

    assign w_accept = start && !kill && (r_state == IDLE);

    // Product and quotient/remainder datapath for the operands presented this cycle.
    always_comb begin
        w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        w_prod_u = {32'd0, a} * {32'd0, b};
        // A zero divisor never commits; substitute 1 so the divider stays defined.
        w_b_safe = (b == 32'd0) ? 32'd1 : b;
        w_abs_a  = a[31] ? (32'd0 - a) : a;
        w_abs_b  = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
        w_uq_mag = w_abs_a / w_abs_b;
        w_ur_mag = w_abs_a % w_abs_b;
        // Magnitude division with sign fix-up; 0x80000000 / -1 wraps to 0x80000000, rem 0.
        w_sq     = (a[31] ^ w_b_safe[31]) ? (32'd0 - w_uq_mag) : w_uq_mag;
        w_sr     = a[31] ? (32'd0 - w_ur_mag) : w_ur_mag;
        w_uq     = a / w_b_safe;
        w_ur     = a % w_b_safe;
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (op)
            OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
            OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
            OP_DIV:   begin w_res_hi = w_sr;            w_res_lo = w_sq;           end
            OP_DIVU:  begin w_res_hi = w_ur;            w_res_lo = w_uq;           end
            default:  begin w_res_hi = 32'd0;           w_res_lo = 32'd0;          end
        endcase
    end

    // Control FSM: accept, latency countdown, commit to HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_res_hi    <= 32'd0;
            r_res_lo    <= 32'd0;
            r_no_commit <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_res_hi    <= w_res_hi;
                                r_res_lo    <= w_res_lo;
                                r_no_commit <= 1'b0;
                                r_cnt       <= CNT_W'(MULT_CYCLES);
                                r_busy      <= 1'b1;
                                r_state     <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_res_hi    <= w_res_hi;
                                r_res_lo    <= w_res_lo;
                                r_no_commit <= (b == 32'd0);
                                r_cnt       <= CNT_W'(DIV_CYCLES);
                                r_busy      <= 1'b1;
                                r_state     <= RUN;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        if (!r_no_commit) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic        kill = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .kill(kill),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // The hazard unit never issues while busy; flag it if the bench ever does.
    always @(posedge clk) begin
        if (!reset && start && busy) begin
            bad = bad + 1;
            $display("FAIL start_while_busy: start=1 busy=%0b required no start", busy);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference HI/LO after one accepted op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] h,
                                             input logic [31:0] l);
        longint sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin sq = sx * sy; return sq; end
            3'd1: begin p = ux * uy; return p; end
            3'd2: begin
                if (y == 32'd0) return {h, l};
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            3'd3: begin
                if (y == 32'd0) return {h, l};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            3'd4: return {x, l};
            3'd5: return {h, x};
            default: return {h, l};
        endcase
    endfunction

    // Expected busy length for an accepted op.
    function automatic int exp_cycles(input logic [2:0] o);
        if (o <= 3'd1) return MULT_N;
        if (o <= 3'd3) return DIV_N;
        return 0;
    endfunction

    // Issue one op at the current negedge, scramble operands after accept,
    // then measure busy length and whether hi/lo held steady while busy.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic k, input logic kill_run,
                         output int bcycles, output bit stable);
        logic [31:0] h0, l0;
        start = 1'b1; op = o; a = x; b = y; kill = k;
        @(negedge clk);
        start = 1'b0; kill = kill_run; op = 3'($urandom_range(0, 7));
        a = $urandom; b = $urandom;
        h0 = hi; l0 = lo;
        bcycles = 0; stable = 1'b1;
        while (busy && bcycles < 200) begin
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            bcycles++;
            @(negedge clk);
        end
        kill = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%0b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        int n; bit st;
        do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, n, st);
        total++;
        if (n != MULT_N || !st) begin
            bad++;
            $display("FAIL mult_busy: cycles=%0d stable=%0b required %0d/1", n, st, MULT_N);
        end
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            bad++;
            $display("FAIL mult_result: hi=%h lo=%h required ffffffff/fffffffa", hi, lo);
        end
        m_hi = hi === 32'hFFFFFFFF ? 32'hFFFFFFFF : 32'hFFFFFFFF;
        m_lo = 32'hFFFFFFFA;
    endtask

    task automatic test_div();
        int n; bit st;
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, n, st);
        total++;
        if (n != DIV_N || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            bad++;
            $display("FAIL div_signed: cycles=%0d hi=%h lo=%h required %0d/ffffffff/fffffffd",
                     n, hi, lo, DIV_N);
        end
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, n, st);
        total++;
        if (n != DIV_N || hi !== 32'd1 || lo !== 32'h7FFFFFFC) begin
            bad++;
            $display("FAIL div_unsigned: cycles=%0d hi=%h lo=%h required %0d/00000001/7ffffffc",
                     n, hi, lo, DIV_N);
        end
    endtask

    task automatic test_mthi_mtlo_divzero();
        int n1, n2, n; bit st;
        do_op(3'd4, 32'h1234, 32'd0, 1'b0, 1'b0, n1, st);
        total++;
        if (hi !== 32'h1234 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi: hi=%h busy=%0b required 00001234/0", hi, busy);
        end
        do_op(3'd5, 32'h5678, 32'd0, 1'b0, 1'b0, n2, st);
        total++;
        if (n1 != 0 || n2 != 0 || hi !== 32'h1234 || lo !== 32'h5678) begin
            bad++;
            $display("FAIL mtlo: busy=%0d/%0d hi=%h lo=%h required 0/0/00001234/00005678",
                     n1, n2, hi, lo);
        end
        do_op(3'd2, 32'h99, 32'd0, 1'b0, 1'b0, n, st);
        total++;
        if (n != DIV_N || hi !== 32'h1234 || lo !== 32'h5678) begin
            bad++;
            $display("FAIL div_by_zero: cycles=%0d hi=%h lo=%h required %0d/00001234/00005678",
                     n, hi, lo, DIV_N);
        end
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, n, st);
        total++;
        if (n != DIV_N || hi !== 32'd0 || lo !== 32'h80000000) begin
            bad++;
            $display("FAIL div_overflow: cycles=%0d hi=%h lo=%h required %0d/00000000/80000000",
                     n, hi, lo, DIV_N);
        end
        m_hi = 32'd0; m_lo = 32'h80000000;
    endtask

    task automatic test_kill();
        int n; bit st;
        do_op(3'd0, 32'd7, 32'd9, 1'b1, 1'b0, n, st);
        total++;
        if (n != 0 || hi !== m_hi || lo !== m_lo) begin
            bad++;
            $display("FAIL kill_start: cycles=%0d hi=%h lo=%h required 0/%h/%h", n, hi, lo, m_hi, m_lo);
        end
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, n, st);
        total++;
        if (n != MULT_N || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++;
            $display("FAIL kill_in_run: cycles=%0d hi=%h lo=%h required %0d/fffffffe/00000001",
                     n, hi, lo, MULT_N);
        end
        m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
    endtask

    task automatic test_reset_mid();
        int late;
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%0b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        late = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL reset_no_late_commit: bad_cycles=%0d required 0", late);
        end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_back_to_back();
        int n; bit st;
        do_op(3'd0, 32'd3, 32'd4, 1'b0, 1'b0, n, st);
        total++;
        if (n != MULT_N || lo !== 32'd12 || hi !== 32'd0) begin
            bad++;
            $display("FAIL b2b_mult: cycles=%0d hi=%h lo=%h required %0d/0/0000000c", n, hi, lo, MULT_N);
        end
        do_op(3'd2, 32'd20, 32'd6, 1'b0, 1'b0, n, st);
        total++;
        if (n != DIV_N || !st || lo !== 32'd3 || hi !== 32'd2) begin
            bad++;
            $display("FAIL b2b_div: cycles=%0d stable=%0b hi=%h lo=%h required %0d/1/2/3",
                     n, st, hi, lo, DIV_N);
        end
        m_hi = 32'd2; m_lo = 32'd3;
    endtask

    task automatic test_random();
        int n; bit st;
        logic [2:0] o; logic [31:0] x, y; logic k;
        logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            k = ($urandom_range(0, 7) == 0);
            e = k ? {m_hi, m_lo} : ref_calc(o, x, y, m_hi, m_lo);
            do_op(o, x, y, k, 1'($urandom_range(0, 1)), n, st);
            total++;
            if (n != (k ? 0 : exp_cycles(o)) || !st || hi !== e[63:32] || lo !== e[31:0]) begin
                bad++;
                $display("FAIL random_%0d: op=%0d kill=%0b a=%h b=%h cycles=%0d stable=%0b hi=%h lo=%h required cycles=%0d hi=%h lo=%h",
                         i, o, k, x, y, n, st, hi, lo, k ? 0 : exp_cycles(o), e[63:32], e[31:0]);
            end
            m_hi = e[63:32]; m_lo = e[31:0];
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo_divzero();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
